// File: rtl/csa_accumulator_pkg.sv
// Shared definitions for the carry-save accumulator: FSM states and
// elaboration-time helpers that size the 3:2 reduction tree.
package csa_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    // Each layer turns every full group of three vectors into two and passes
    // the remainder through unchanged.
    function automatic int csa_layer_count(input int n_in, input int layer);
        int n;
        n = n_in;
        for (int l = 0; l < layer; l++) begin
            if (n > 2) n = 2 * (n / 3) + n % 3;
        end
        return n;
    endfunction

    function automatic int csa_depth(input int n_in);
        int n;
        int d;
        n = n_in;
        d = 0;
        for (int i = 0; i < 64; i++) begin
            if (n > 2) begin
                n = 2 * (n / 3) + n % 3;
                d++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/csa_accumulator_row.sv
// One row of 3:2 compressors; the carry vector is already weighted (shifted
// left by one) and wraps at the row width.
module csa_row #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-1:0] maj;

    assign sum   = a ^ b ^ c;
    assign maj   = (a & b) | (a & c) | (b & c);
    assign carry = maj << 1;

endmodule

// File: rtl/csa_accumulator.sv
// Multi-operand accumulator: beats fold into a redundant sum/carry pair via a
// CSA tree; one carry-propagate add resolves the packet total.
module csa_accumulator
    import csa_accumulator_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_OPS   = 4,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_WIDTH-1:0]     out_data,
    output logic [CNT_WIDTH-1:0]     out_beats
);

    localparam int NIN   = NUM_OPS + 2;
    localparam int DEPTH = csa_depth(NIN);

    state_t               state, state_nx;
    logic [ACC_WIDTH-1:0] acc_sum, acc_carry;
    logic [ACC_WIDTH-1:0] red_sum, red_carry;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 in_hs, out_hs;

    assign in_ready = (state == ST_ACCUM);
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    // Layer 0 holds the zero-extended operands plus the running pair; each
    // later layer reduces the previous one until two vectors remain.
    generate
        for (genvar l = 0; l <= DEPTH; l++) begin : lay
            localparam int N = csa_layer_count(NIN, l);
            logic [ACC_WIDTH-1:0] v [N];
            if (l == 0) begin : g_in
                for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
                    assign v[k] = ACC_WIDTH'(in_data[k*WIDTH +: WIDTH]);
                end
                assign v[NUM_OPS]   = acc_sum;
                assign v[NUM_OPS+1] = acc_carry;
            end else begin : g_red
                localparam int NP = csa_layer_count(NIN, l - 1);
                localparam int G  = NP / 3;
                for (genvar g = 0; g < G; g++) begin : g_row
                    csa_row #(.W(ACC_WIDTH)) u_row (
                        .a    (lay[l-1].v[3*g]),
                        .b    (lay[l-1].v[3*g+1]),
                        .c    (lay[l-1].v[3*g+2]),
                        .sum  (v[2*g]),
                        .carry(v[2*g+1])
                    );
                end
                for (genvar r = 0; r < NP % 3; r++) begin : g_pass
                    assign v[2*G+r] = lay[l-1].v[3*G+r];
                end
            end
        end
    endgenerate

    assign red_sum   = lay[DEPTH].v[0];
    assign red_carry = lay[DEPTH].v[1];

    always_ff @(posedge clk) begin
        if (rst) state <= ST_ACCUM;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_ACCUM:   if (in_hs && in_last) state_nx = ST_RESOLVE;
            ST_RESOLVE: state_nx = ST_HOLD;
            ST_HOLD:    if (out_hs) state_nx = ST_ACCUM;
            default:    state_nx = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_sum   <= '0;
            acc_carry <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
        end else begin
            if (in_hs) begin
                acc_sum   <= red_sum;
                acc_carry <= red_carry;
                if (cnt != '1) cnt <= cnt + CNT_WIDTH'(1);
            end
            if (state == ST_RESOLVE) begin
                out_data  <= acc_sum + acc_carry;
                out_beats <= cnt;
                out_valid <= 1'b1;
            end
            // Result consumed: start the next packet from a clean accumulator.
            if (out_hs) begin
                out_valid <= 1'b0;
                acc_sum   <= '0;
                acc_carry <= '0;
                cnt       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// Self-checking bench: directed cases plus random packets against a plain
// arithmetic sum model.
module tb_csa_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last, out_valid, out_ready;
    logic [31:0] in_data;
    logic [15:0] out_data;
    logic [7:0]  out_beats;

    logic        s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready;
    logic [31:0] s_in_data;
    logic [15:0] s_out_data;
    logic [1:0]  s_out_beats;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csa_accumulator #(.WIDTH(8), .NUM_OPS(4), .ACC_WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_beats(out_beats)
    );

    csa_accumulator #(.WIDTH(8), .NUM_OPS(4), .ACC_WIDTH(16), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_beats(s_out_beats)
    );

    function automatic int beat_sum(input logic [31:0] d);
        return int'(d[7:0]) + int'(d[15:8]) + int'(d[23:16]) + int'(d[31:24]);
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic last);
        int w;
        w = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_data = $urandom; in_last = 1'($urandom);
    endtask

    task automatic get_result(output logic [15:0] d, output logic [7:0] b);
        int w;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL result_timeout: out_valid stayed %b, required 1", out_valid);
        end
        d = out_data; b = out_beats;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++;
        if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h, required 0000", out_data); end
        checks++;
        if (out_beats !== 8'h0) begin errors++; $display("FAIL reset_out_beats: got %h, required 00", out_beats); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_single;
        send_beat({8'd4, 8'd3, 8'd2, 8'd1}, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL single_t1: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: out_valid=%b at t+2, required 1", out_valid); end
        checks++;
        if (out_data !== 16'h000A || out_beats !== 8'd1) begin
            errors++; $display("FAIL single_result: got %h/%0d, required 000a/1", out_data, out_beats);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL single_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_multi;
        logic [15:0] d;
        logic [7:0]  b;
        for (int gap = 0; gap <= 2; gap += 2) begin
            for (int i = 0; i < 3; i++) begin
                repeat (gap) @(posedge clk);
                send_beat(32'hFFFF_FFFF, i == 2);
            end
            get_result(d, b);
            checks++;
            if (d !== 16'h0BF4 || b !== 8'd3) begin
                errors++; $display("FAIL multi_gap%0d: got %h/%0d, required 0bf4/3", gap, d, b);
            end
        end
    endtask

    task automatic test_wrap;
        logic [15:0] d;
        logic [7:0]  b;
        for (int i = 0; i < 65; i++) send_beat(32'hFFFF_FFFF, i == 64);
        get_result(d, b);
        checks++;
        if (d !== 16'h02FC || b !== 8'd65) begin
            errors++; $display("FAIL wrap: got %h/%0d, required 02fc/65", d, b);
        end
    endtask

    task automatic test_hold;
        logic [15:0] d;
        logic [7:0]  b;
        int w;
        w = 0;
        send_beat(32'h0102_0304, 1'b1);
        @(negedge clk);
        while (!out_valid && w < 20) begin @(negedge clk); w++; end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b, required 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h000A || out_beats !== 8'd1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable[%0d]: v=%b d=%h b=%0d rdy=%b, required 1 000a 1 0",
                         i, out_valid, out_data, out_beats, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        send_beat({8'd1, 8'd0, 8'd0, 8'd0}, 1'b1);
        get_result(d, b);
        checks++;
        if (d !== 16'h0001 || b !== 8'd1) begin
            errors++; $display("FAIL hold_cleared: got %h/%0d, required 0001/1", d, b);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] d;
        logic [7:0]  b;
        send_beat(32'h1010_1010, 1'b0);
        send_beat(32'h1010_1010, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_during: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        rst = 1'b0;
        send_beat({8'd0, 8'd0, 8'd0, 8'd5}, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early_valid: got %b, required 0", out_valid); end
        get_result(d, b);
        checks++;
        if (d !== 16'h0005 || b !== 8'd1) begin
            errors++; $display("FAIL rstmid_result: got %h/%0d, required 0005/1", d, b);
        end
    endtask

    task automatic test_saturate;
        int w;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_in_valid = 1'b1; s_in_data = 32'h0000_0001; s_in_last = (i == 4);
            checks++;
            if (s_in_ready !== 1'b1) begin errors++; $display("FAIL sat_ready[%0d]: got %b, required 1", i, s_in_ready); end
            @(posedge clk);
            #1 s_in_valid = 1'b0;
        end
        w = 0;
        @(negedge clk);
        while (!s_out_valid && w < 20) begin @(negedge clk); w++; end
        checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== 16'd5 || s_out_beats !== 2'd3) begin
            errors++; $display("FAIL saturate: v=%b d=%0d b=%0d, required 1 5 3", s_out_valid, s_out_data, s_out_beats);
        end
        s_out_ready = 1'b1;
        @(posedge clk);
        #1 s_out_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [15:0] d;
        logic [7:0]  b;
        logic [31:0] beat;
        int n, exp_sum;
        for (int p = 0; p < 20; p++) begin
            n = $urandom_range(1, 10);
            exp_sum = 0;
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                beat = $urandom;
                exp_sum += beat_sum(beat);
                send_beat(beat, i == n - 1);
            end
            get_result(d, b);
            checks++;
            if (d !== 16'(exp_sum) || b !== 8'(n)) begin
                errors++; $display("FAIL random[%0d]: got %h/%0d, required %h/%0d", p, d, b, 16'(exp_sum), n);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_in_last = 1'b0; s_out_ready = 1'b0;
        test_reset;
        test_single;
        test_multi;
        test_wrap;
        test_hold;
        test_reset_mid;
        test_saturate;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
